// File: rtl/credit_rd_pkg.sv
// credit_rd_pkg: shared defaults, width helper and status record for the credit read engine
package credit_rd_pkg;
  localparam int DEF_N_CH = 2;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_RD_LAT = 1;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int CRED_W = 16;
  typedef struct packed {
    logic [CRED_W-1:0] credit;
    logic overflow;
  } type_rd_status;
  function automatic int clog2_safe(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/credit_rd_fifo.sv
// credit_rd_fifo: synchronous first-word-fall-through FIFO with sticky overflow flag
module credit_rd_fifo
  import credit_rd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             overflow_sticky
);
  localparam int AW = clog2_safe(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic wr, rd;
  assign wr = push & !full;
  assign rd = pop & !empty;
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      overflow_sticky <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(wr) - CW'(rd);
      if (push & full) overflow_sticky <= 1'b1;
    end
  end
  always_ff @(posedge clk) if (wr) mem[wr_ptr] <= din;
endmodule

// File: rtl/credit_rd_multi.sv
// credit_rd_multi: credit-gated address broadcast to N_CH RAMs, summed into an FWFT output FIFO
// Optional statistics outputs are enabled by defining CREDIT_RD_MULTI_STATS_EN.
module credit_rd_multi
  import credit_rd_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        s_addr_tdata,
  input  logic                     s_addr_tvalid,
  output logic                     s_addr_tready,
  output logic [N_CH-1:0]          mem_rd_en,
  output logic [N_CH*ADDR_W-1:0]   mem_rd_addr,
  input  logic [N_CH*DATA_W-1:0]   mem_rd_data,
  output logic [DATA_W-1:0]        m_data_tdata,
  output logic                     m_data_tvalid,
  input  logic                     m_data_tready,
  output logic                     fifo_overflow,
  output logic [$clog2(FIFO_DEPTH):0] credit_cnt
`ifdef CREDIT_RD_MULTI_STATS_EN
  ,
  output logic [31:0]              stat_addr_cnt,
  output logic [31:0]              stat_data_cnt,
  output logic [$clog2(FIFO_DEPTH):0] stat_max_used
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic reset_n_q, acc, pop, push, empty, full, ovf;
  logic [CRED_W-1:0] cred;
  logic [RD_LAT-1:0] vld;
  logic [DATA_W-1:0] sum, dout;
  type_rd_status st;
  assign st = '{credit: cred, overflow: ovf};
  assign s_addr_tready = reset_n_q & (st.credit != '0);
  assign acc = s_addr_tvalid & s_addr_tready;
  assign pop = m_data_tvalid & m_data_tready;
  assign push = vld[RD_LAT-1];
  assign credit_cnt = st.credit[CW-1:0];
  assign fifo_overflow = st.overflow;
  assign m_data_tvalid = !empty;
  assign m_data_tdata = empty ? '0 : dout;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reset_n_q <= 1'b0;
      cred <= CRED_W'(FIFO_DEPTH);
      mem_rd_en <= '0;
      mem_rd_addr <= '0;
      vld <= '0;
    end else begin
      reset_n_q <= 1'b1;
      cred <= cred - CRED_W'(acc) + CRED_W'(pop);
      mem_rd_en <= {N_CH{acc}};
      if (acc) mem_rd_addr <= {N_CH{s_addr_tdata}};
      vld[0] <= mem_rd_en[0];
      for (int i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
    end
  end
  // lanes are summed at the tail of the issue pipe, when RAM data is valid
  always_comb begin
    sum = '0;
    for (int k = 0; k < N_CH; k++) sum = sum + mem_rd_data[k*DATA_W +: DATA_W];
  end
  credit_rd_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .pop(pop),
    .din(sum),
    .dout(dout),
    .empty(empty),
    .full(full),
    .overflow_sticky(ovf)
  );
`ifdef CREDIT_RD_MULTI_STATS_EN
  logic [CW-1:0] used;
  assign used = CW'(FIFO_DEPTH) - credit_cnt;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_addr_cnt <= '0;
      stat_data_cnt <= '0;
      stat_max_used <= '0;
    end else begin
      stat_addr_cnt <= stat_addr_cnt + 32'(acc);
      stat_data_cnt <= stat_data_cnt + 32'(pop);
      if (used > stat_max_used) stat_max_used <= used;
    end
  end
`endif
endmodule

// File: tb/tb_credit_rd_multi.sv
// tb_credit_rd_multi: randomized scoreboard bench for credit_rd_multi with a RAM and sum reference model
module tb_credit_rd_multi;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] s_addr_tdata = '0;
  logic s_addr_tvalid = 1'b0;
  logic s_addr_tready;
  logic [1:0] mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [31:0] mem_rd_data = '0;
  logic [15:0] m_data_tdata;
  logic m_data_tvalid;
  logic m_data_tready = 1'b1;
  logic fifo_overflow;
  logic [3:0] credit_cnt;
  logic [7:0] s4_addr = '0;
  logic s4_valid = 1'b0;
  logic s4_ready;
  logic [3:0] en4;
  logic [31:0] addr4;
  logic [63:0] rd4 = '0;
  logic [15:0] m4_data;
  logic m4_valid;
  logic ovf4;
  logic [3:0] cred4;
`ifdef CREDIT_RD_MULTI_STATS_EN
  logic [31:0] stat_addr_cnt, stat_data_cnt, sa4, sd4;
  logic [3:0] stat_max_used, sm4;
`endif
  typedef struct {
    logic [15:0] d;
    int cyc;
    bit lat;
  } ent_t;
  ent_t exp[$];
  int total = 0, bad = 0, cyc = 0, n_acc = 0, n_pop = 0;
  bit lat_mode = 1'b0, rnd = 1'b0;
  logic [15:0] ram0 [256];
  logic [15:0] ram1 [256];

  credit_rd_multi #(.N_CH(2), .ADDR_W(8), .DATA_W(16), .RD_LAT(1), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_addr_tdata(s_addr_tdata), .s_addr_tvalid(s_addr_tvalid), .s_addr_tready(s_addr_tready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .m_data_tdata(m_data_tdata), .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready),
    .fifo_overflow(fifo_overflow), .credit_cnt(credit_cnt)
`ifdef CREDIT_RD_MULTI_STATS_EN
    , .stat_addr_cnt(stat_addr_cnt), .stat_data_cnt(stat_data_cnt), .stat_max_used(stat_max_used)
`endif
  );

  credit_rd_multi #(.N_CH(4), .ADDR_W(8), .DATA_W(16), .RD_LAT(1), .FIFO_DEPTH(8)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .s_addr_tdata(s4_addr), .s_addr_tvalid(s4_valid), .s_addr_tready(s4_ready),
    .mem_rd_en(en4), .mem_rd_addr(addr4), .mem_rd_data(rd4),
    .m_data_tdata(m4_data), .m_data_tvalid(m4_valid), .m_data_tready(1'b1),
    .fifo_overflow(ovf4), .credit_cnt(cred4)
`ifdef CREDIT_RD_MULTI_STATS_EN
    , .stat_addr_cnt(sa4), .stat_data_cnt(sd4), .stat_max_used(sm4)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram0[i] = 16'(i);
      ram1[i] = 16'(i * 256);
    end
  end

  // RAMs with one clock of read latency
  always @(posedge clk) begin
    if (mem_rd_en[0]) mem_rd_data[15:0] <= ram0[mem_rd_addr[7:0]];
    if (mem_rd_en[1]) mem_rd_data[31:16] <= ram1[mem_rd_addr[15:8]];
    for (int k = 0; k < 4; k++)
      if (en4[k]) rd4[k*16 +: 16] <= (addr4[k*8 +: 8] == 8'd5) ? 16'hFFFF : {8'h00, addr4[k*8 +: 8]};
  end

  // output backpressure generator for the random phase
  initial begin
    forever begin
      if (rnd) begin
        m_data_tready = 1'b0;
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1 m_data_tready = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  end

  // monitor: credits, hold stability, and in-order data checking
  bit pv = 1'b0, pr = 1'b0;
  logic [15:0] pd = '0;
  always @(negedge clk) begin
    ent_t e;
    if (!reset_n) pv = 1'b0;
    else begin
      total++;
      if (int'(credit_cnt) != 8 - n_acc + n_pop) begin
        bad++;
        $display("FAIL credit act=%0d req=%0d", credit_cnt, 8 - n_acc + n_pop);
      end
      if (pv && !pr) begin
        total++;
        if (!m_data_tvalid || m_data_tdata !== pd) begin
          bad++;
          $display("FAIL hold act=%0b/%h req=1/%h", m_data_tvalid, m_data_tdata, pd);
        end
      end
      if (s_addr_tvalid && s_addr_tready) n_acc++;
      if (m_data_tvalid && m_data_tready) begin
        n_pop++;
        total++;
        if (exp.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat act=%h req=none", m_data_tdata);
        end else begin
          e = exp.pop_front();
          if (m_data_tdata !== e.d) begin
            bad++;
            $display("FAIL data act=%h req=%h", m_data_tdata, e.d);
          end
          if (e.lat) begin
            total++;
            if (cyc - e.cyc != 3) begin
              bad++;
              $display("FAIL latency act=%0d req=3", cyc - e.cyc);
            end
          end
        end
      end
      pv = m_data_tvalid;
      pr = m_data_tready;
      pd = m_data_tdata;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] a);
    int n;
    n = 0;
    s_addr_tdata = a;
    s_addr_tvalid = 1'b1;
    @(negedge clk);
    while (!s_addr_tready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (s_addr_tready) exp.push_back('{16'(32'h0101 * a), cyc, lat_mode});
    else begin
      total++;
      bad++;
      $display("FAIL send_timeout addr=%h act=0 req=1", a);
    end
    @(posedge clk);
    #1 s_addr_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1 reset_n = 1'b0;
    s_addr_tvalid = 1'b0;
    s4_valid = 1'b0;
    exp.delete();
    n_acc = 0;
    n_pop = 0;
    repeat (cycles) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic send4(input logic [7:0] a, input logic [15:0] req);
    int n;
    n = 0;
    s4_addr = a;
    s4_valid = 1'b1;
    @(negedge clk);
    while (!s4_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 s4_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!m4_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("sum4", int'(m4_data), int'(req));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    do_reset(3);
    @(negedge clk);
    chk("rst_credit", int'(credit_cnt), 8);
    chk("rst_ready", int'(s_addr_tready), 0);
    chk("rst_en", int'(mem_rd_en), 0);
    chk("rst_addr", int'(mem_rd_addr), 0);
    chk("rst_valid", int'(m_data_tvalid), 0);
    chk("rst_tdata", int'(m_data_tdata), 0);
    chk("rst_ovf", int'(fifo_overflow), 0);
    @(negedge clk);
    chk("ready_after_rst", int'(s_addr_tready), 1);
    // wrap-around sum on the four-channel instance
    send4(8'd5, 16'hFFFC);
    send4(8'd7, 16'd28);
    // basic streaming
    lat_mode = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) send(8'(i));
    lat_mode = 1'b0;
    drain();
    chk("basic_ovf", int'(fifo_overflow), 0);
    // backpressure fills exactly the credit window
    m_data_tready = 1'b0;
    a = 0;
    for (int i = 0; i < 30; i++) begin
      s_addr_tdata = 8'(100 + a);
      s_addr_tvalid = 1'b1;
      @(negedge clk);
      if (s_addr_tready) begin
        exp.push_back('{16'(32'h0101 * (100 + a)), cyc, 1'b0});
        a++;
      end
      @(posedge clk);
      #1;
    end
    s_addr_tvalid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", a, 8);
    chk("bp_credit", int'(credit_cnt), 0);
    chk("bp_ready", int'(s_addr_tready), 0);
    @(posedge clk);
    #1 m_data_tready = 1'b1;
    for (int i = a; i < 20; i++) send(8'(100 + i));
    drain();
    // random gaps on both sides
    rnd = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 send(8'($urandom));
    end
    drain();
    rnd = 1'b0;
    repeat (8) @(posedge clk);
    #1 m_data_tready = 1'b1;
    @(negedge clk);
    chk("rand_credit", int'(credit_cnt), 8);
    chk("rand_ovf", int'(fifo_overflow), 0);
    // reset with reads in flight and beats parked in the FIFO
    m_data_tready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(40 + i));
    do_reset(2);
    @(negedge clk);
    chk("midrst_credit", int'(credit_cnt), 8);
    chk("midrst_valid", int'(m_data_tvalid), 0);
    @(posedge clk);
    #1 m_data_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 send(8'd3);
    drain();
    chk("midrst_pops", n_pop, 1);
`ifdef CREDIT_RD_MULTI_STATS_EN
    do_reset(2);
    m_data_tready = 1'b0;
    for (int i = 0; i < 7; i++) send(8'(i));
    m_data_tready = 1'b1;
    drain();
    m_data_tready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(i));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stat_addr", int'(stat_addr_cnt), 10);
    chk("stat_data", int'(stat_data_cnt), 7);
    chk("stat_max", int'(stat_max_used), 7);
    @(posedge clk);
    #1 m_data_tready = 1'b1;
    drain();
`endif
    chk("final_ovf", int'(fifo_overflow), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
